ber_test_ctrl: RTL and testbench

Sequencer for a byte-wise BER measurement.
- Runs a PRBS-8 test burst into the link transmitter.
- Keeps each sent byte in a FIFO until the matching received byte returns, so link latency is hidden.
- Drives a downstream Hamming-distance/BER accumulator with aligned (sent, recv) pairs plus a valid strobe.
- Sits between the test-start/LCD control logic and the link TX/RX byte streams.

---
 rtl/ber_test_pkg.sv | 23 ++
 rtl/ber_pair_fifo.sv | 55 +++++
 rtl/ber_test_ctrl.sv | 146 ++++++++++++++
 tb/tb_ber_test_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_test_pkg.sv
// Shared types and PRBS-8 helpers for the BER test sequencer.
package ber_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ber_state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Feedback is the parity of bits 7,5,4,3 shifted into bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [7:0] lfsr8_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/ber_pair_fifo.sv
// In-flight byte FIFO: holds each transmitted byte until its echo returns.
module ber_pair_fifo #(
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// BER measurement sequencer: PRBS-8 burst out, echo pairing through the
// in-flight FIFO, aligned (sent, recv) pairs out to the BER accumulator.
//
//   state | meaning
//   IDLE  | waiting for start, FIFO flushed
//   RUN   | transmitting PRBS bytes, pairing returned bytes
//   DRAIN | all bytes sent, waiting for echoes or timeout
//   DONE  | one-cycle completion pulse
module ber_test_ctrl
    import ber_test_pkg::*;
#(
    parameter logic [31:0] NUM_BYTES     = 32'd1_000_000,
    parameter int          FIFO_AW       = 4,
    parameter logic [7:0]  PRBS_SEED     = 8'hFF,
    parameter logic [31:0] DRAIN_TIMEOUT = 32'd1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        ber_valid,
    output logic [7:0]  ber_sent,
    output logic [7:0]  ber_recv,
    output logic        busy,
    output logic        done,
    output logic        sync_err,
    output logic [31:0] bytes_compared
);

    localparam logic [7:0] SEED = lfsr8_seed(PRBS_SEED);

    ber_state_t       state;
    ber_state_t       state_nxt;
    logic [7:0]       lfsr;
    logic [31:0]      tx_cnt;
    logic [31:0]      drain_tmr;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             fifo_flush;
    logic             fifo_push;
    logic             fifo_pop;
    logic             run_start;
    logic             tx_fire;
    logic             last_byte;
    logic             rx_active;
    logic             drain_exit;

    assign run_start  = (state == IDLE) && start && !abort;
    assign tx_fire    = tx_valid && tx_ready;
    assign last_byte  = (tx_cnt == NUM_BYTES - 32'd1);
    assign rx_active  = ((state == RUN) || (state == DRAIN)) && !abort;
    assign fifo_push  = tx_fire && !abort;
    assign fifo_pop   = rx_active && rx_valid && !fifo_empty;
    assign fifo_flush = abort || run_start || (state == DONE);
    // The timeout fires on the Nth consecutive cycle without rx_valid.
    assign drain_exit = (fifo_count == '0) ||
                        (!rx_valid && (drain_tmr == DRAIN_TIMEOUT - 32'd1));

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                tx_valid = !fifo_full;
                if (tx_valid && tx_ready && last_byte) state_nxt = DRAIN;
            end
            DRAIN: if (drain_exit) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    assign tx_data = lfsr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr           <= SEED;
            tx_cnt         <= '0;
            drain_tmr      <= '0;
            ber_valid      <= 1'b0;
            ber_sent       <= '0;
            ber_recv       <= '0;
            sync_err       <= 1'b0;
            bytes_compared <= '0;
        end else begin
            ber_valid <= fifo_pop;
            if (fifo_pop) begin
                ber_sent <= fifo_head;
                ber_recv <= rx_data;
                if (bytes_compared != 32'hFFFF_FFFF)
                    bytes_compared <= bytes_compared + 32'd1;
            end
            if (rx_active && rx_valid && fifo_empty)
                sync_err <= 1'b1;
            if (state == DRAIN)
                drain_tmr <= rx_valid ? 32'd0 : drain_tmr + 32'd1;
            else
                drain_tmr <= '0;
            if (tx_fire) begin
                lfsr   <= lfsr8_next(lfsr);
                tx_cnt <= tx_cnt + 32'd1;
            end
            if (run_start) begin
                lfsr           <= SEED;
                tx_cnt         <= '0;
                sync_err       <= 1'b0;
                bytes_compared <= '0;
            end
        end
    end

    ber_pair_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Directed bench for ber_test_ctrl: a depth-4 instance for loopback, backpressure,
// sync and abort cases, and a 4-byte instance for the drain timeout case.
module tb_ber_test_ctrl;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        tx_valid,   tx_valid_b;
    logic [7:0]  tx_data,    tx_data_b;
    logic        ber_valid,  ber_valid_b;
    logic [7:0]  ber_sent,   ber_sent_b;
    logic [7:0]  ber_recv,   ber_recv_b;
    logic        busy,       busy_b;
    logic        done,       done_b;
    logic        sync_err,   sync_err_b;
    logic [31:0] bytes_compared, bytes_compared_b;

    logic [7:0] exp_tx [6];
    int n_checks;
    int n_pass;

    ber_test_ctrl #(
        .NUM_BYTES (32'd6), .FIFO_AW (2), .PRBS_SEED (8'hFF), .DRAIN_TIMEOUT (32'd8)
    ) dut (
        .CLK (CLK), .RST (RST), .start (start), .abort (abort),
        .tx_ready (tx_ready), .tx_valid (tx_valid), .tx_data (tx_data),
        .rx_valid (rx_valid), .rx_data (rx_data),
        .ber_valid (ber_valid), .ber_sent (ber_sent), .ber_recv (ber_recv),
        .busy (busy), .done (done), .sync_err (sync_err),
        .bytes_compared (bytes_compared)
    );

    ber_test_ctrl #(
        .NUM_BYTES (32'd4), .FIFO_AW (4), .PRBS_SEED (8'hFF), .DRAIN_TIMEOUT (32'd8)
    ) dut_b (
        .CLK (CLK), .RST (RST), .start (start), .abort (abort),
        .tx_ready (tx_ready), .tx_valid (tx_valid_b), .tx_data (tx_data_b),
        .rx_valid (rx_valid), .rx_data (rx_data),
        .ber_valid (ber_valid_b), .ber_sent (ber_sent_b), .ber_recv (ber_recv_b),
        .busy (busy_b), .done (done_b), .sync_err (sync_err_b),
        .bytes_compared (bytes_compared_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0; start = 1'b0; abort = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(); step();
        RST = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Loopback with 3-cycle echo latency; byte index `corrupt` has bit 0 flipped.
    task automatic run_loopback(input int corrupt);
        int ntx, npair, ndone, r;
        int txcyc [8];
        logic [7:0] flip;
        ntx = 0; npair = 0; ndone = 0; r = 0;
        tx_ready = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 20; cyc++) begin
            rx_valid = 1'b0;
            if (tx_valid && tx_ready) begin
                if (ntx < 6) check("lb_tx_data", tx_data, exp_tx[ntx]);
                txcyc[ntx % 8] = cyc;
                ntx++;
            end
            if (ber_valid) begin
                if (npair < 6) begin
                    flip = (npair == corrupt) ? 8'h01 : 8'h00;
                    check("lb_ber_sent", ber_sent, exp_tx[npair]);
                    check("lb_ber_recv", ber_recv, exp_tx[npair] ^ flip);
                end
                npair++;
            end
            if (done) ndone++;
            if (r < ntx && r < 6 && txcyc[r] + 3 == cyc) begin
                rx_valid = 1'b1;
                rx_data  = exp_tx[r] ^ ((r == corrupt) ? 8'h01 : 8'h00);
                r++;
            end
            step();
        end
        rx_valid = 1'b0;
        check("lb_tx_count", ntx, 6);
        check("lb_pairs", npair, 6);
        check("lb_done_pulses", ndone, 1);
        check("lb_bytes_compared", bytes_compared, 6);
        check("lb_sync_err", sync_err, 0);
        check("lb_busy_end", busy, 0);
    endtask

    initial begin
        int ntx, npair, ndone, done_cyc, extra;
        n_checks = 0;
        n_pass   = 0;
        exp_tx = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

        // reset values, sampled while reset is held
        RST = 1'b0; start = 1'b0; abort = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ber_valid", ber_valid, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_bytes_compared", bytes_compared, 0);
        RST = 1'b1;
        step();

        // 1: clean loopback, 2: bit-0 error on the third byte
        run_loopback(-1);
        do_reset();
        run_loopback(2);

        // 3: depth-4 backpressure, then resume with F0
        do_reset();
        tx_ready = 1'b1;
        pulse_start();
        ntx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (tx_valid) ntx++;
            if (cyc == 4) begin
                check("bp_tx_valid_low", tx_valid, 0);
                check("bp_tx_data_hold", tx_data, 8'hF0);
            end
            step();
        end
        check("bp_handshakes", ntx, 4);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = exp_tx[i];
            step();
            rx_valid = 1'b0;
            check("bp_ber_valid", ber_valid, 1);
            check("bp_ber_sent", ber_sent, exp_tx[i]);
        end
        check("bp_resume_valid", tx_valid, 1);
        check("bp_resume_data", tx_data, 8'hF0);
        check("bp_bytes_compared", bytes_compared, 4);

        // 4: sync error, start/abort priority, sticky across abort, cleared on start
        do_reset();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("se_abort_wins", busy, 0);
        rx_valid = 1'b1; rx_data = 8'h55;
        step();
        rx_valid = 1'b0;
        check("se_idle_rx_ignored", sync_err, 0);
        pulse_start();
        rx_valid = 1'b1; rx_data = 8'hAA;
        step();
        rx_valid = 1'b0;
        check("se_sync_err_set", sync_err, 1);
        check("se_no_ber_valid", ber_valid, 0);
        check("se_bytes_compared", bytes_compared, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("se_sticky_after_abort", sync_err, 1);
        pulse_start();
        check("se_cleared_on_start", sync_err, 0);
        check("se_busy_after_start", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // 5: NUM_BYTES=4, two echoes in DRAIN, timeout of 8 idle cycles
        do_reset();
        tx_ready = 1'b1;
        pulse_start();
        ntx = 0; npair = 0; ndone = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            rx_valid = 1'b0;
            if (tx_valid_b) begin
                if (ntx < 4) check("to_tx_data", tx_data_b, exp_tx[ntx]);
                ntx++;
            end
            if (ber_valid_b) begin
                if (npair < 2) begin
                    check("to_ber_sent", ber_sent_b, exp_tx[npair]);
                    check("to_ber_recv", ber_recv_b, exp_tx[npair]);
                end
                npair++;
            end
            if (done_b) begin
                ndone++;
                done_cyc = cyc;
            end
            if (cyc == 6 || cyc == 7) begin
                rx_valid = 1'b1;
                rx_data  = exp_tx[cyc - 6];
            end
            step();
        end
        rx_valid = 1'b0;
        check("to_tx_count", ntx, 4);
        check("to_pairs", npair, 2);
        check("to_done_pulses", ndone, 1);
        check("to_done_cycle", done_cyc, 16);
        check("to_bytes_compared", bytes_compared_b, 2);
        check("to_sync_err", sync_err_b, 0);

        // 6: abort with three bytes in flight
        do_reset();
        tx_ready = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc == 3) begin
                rx_valid = 1'b1;
                rx_data  = 8'hFF;
            end
            step();
        end
        rx_valid = 1'b0;
        check("ab_pair_before", ber_valid, 1);
        check("ab_pair_sent", ber_sent, 8'hFF);
        abort = 1'b1; tx_ready = 1'b0;
        step();
        abort = 1'b0;
        check("ab_idle", busy, 0);
        check("ab_tx_valid", tx_valid, 0);
        check("ab_bytes_held", bytes_compared, 1);
        extra = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h3C;
            step();
            if (ber_valid || done) extra++;
        end
        rx_valid = 1'b0;
        check("ab_no_pairs_or_done", extra, 0);
        pulse_start();
        check("ab_seed_reload", tx_data, 8'hFF);
        rx_valid = 1'b1; rx_data = 8'hFF;
        step();
        rx_valid = 1'b0;
        check("ab_fifo_flushed", sync_err, 1);
        check("ab_flushed_no_pair", ber_valid, 0);

        // 7: asynchronous reset mid-run
        do_reset();
        tx_ready = 1'b1;
        pulse_start();
        step(); step();
        #2 RST = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_tx_valid", tx_valid, 0);
        check("ar_tx_data", tx_data, 8'hFF);
        step();
        RST = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
